// File: rtl/ula_pkg.sv
// Shared definitions for the sequential stack-machine ALU: funct field
// encodings and the controller state type.
package ula_pkg;

    // Operation field funct[4:2], meaningful when funct[1:0] selects the ALU group
    localparam logic [2:0] OP_BYPASST = 3'b000;
    localparam logic [2:0] OP_AND     = 3'b001;
    localparam logic [2:0] OP_SUB     = 3'b010;
    localparam logic [2:0] OP_OR      = 3'b011;
    localparam logic [2:0] OP_ADD     = 3'b100;
    localparam logic [2:0] OP_XOR     = 3'b101;
    localparam logic [2:0] OP_NSUB    = 3'b110;
    localparam logic [2:0] OP_BYPASSY = 3'b111;

    // Group select funct[1:0]
    localparam logic [1:0] LOW_ALU  = 2'b00;
    localparam logic [1:0] LOW_DIV  = 2'b01;
    localparam logic [1:0] LOW_MULT = 2'b10;
    localparam logic [1:0] LOW_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

endpackage

// File: rtl/ula_seq_if.sv
// Request/result bundle between the control unit (master) and the ALU (slave).
interface ula_seq_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int FUNCT_WIDTH = 5
);
    logic                   start;
    logic [DATA_WIDTH-1:0]  T;
    logic [DATA_WIDTH-1:0]  Y;
    logic [FUNCT_WIDTH-1:0] funct;
    logic                   busy;
    logic                   done;
    logic [DATA_WIDTH-1:0]  Result;
    logic [DATA_WIDTH-1:0]  ResultHi;
    logic                   flagZ;
    logic                   flagN;
    logic                   flagC;
    logic                   flagDZ;

    modport master (
        output start, T, Y, funct,
        input  busy, done, Result, ResultHi, flagZ, flagN, flagC, flagDZ
    );

    modport slave (
        input  start, T, Y, funct,
        output busy, done, Result, ResultHi, flagZ, flagN, flagC, flagDZ
    );
endinterface

// File: rtl/ula_seq_muldiv.sv
// Iterative multiply/divide engine. One bit per clock: shift-add for MULT,
// restoring division for DIV. hi/lo present the value the accumulator takes
// at the next edge, so the caller can capture the final result on the same
// edge that performs the last iteration (flagged by last).
module ula_seq_muldiv #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  go,
    input  logic                  is_div,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo,
    output logic                  last
);
    localparam int CNT_WIDTH = $clog2(DATA_WIDTH) + 1;

    logic [DATA_WIDTH-1:0] acc_hi;
    logic [DATA_WIDTH-1:0] acc_lo;
    logic [DATA_WIDTH-1:0] operand_b;
    logic                  div_mode;
    logic                  running;
    logic [CNT_WIDTH-1:0]  cnt;

    logic [DATA_WIDTH:0]   mul_sum;
    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH:0]   diff;

    // One iteration step: multiplier bit in acc_lo[0] adds b into the high half
    // and the pair shifts right; for division the partial remainder shifts left
    // and b is subtracted back out unless that would go negative (diff MSB set).
    always_comb begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand_b} : '0);
        shifted = {acc_hi, acc_lo[DATA_WIDTH-1]};
        diff    = shifted - {1'b0, operand_b};
        if (div_mode) begin
            hi = diff[DATA_WIDTH] ? shifted[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
            lo = {acc_lo[DATA_WIDTH-2:0], ~diff[DATA_WIDTH]};
        end else begin
            hi = mul_sum[DATA_WIDTH:1];
            lo = {mul_sum[0], acc_lo[DATA_WIDTH-1:1]};
        end
    end

    assign last = running && (cnt == CNT_WIDTH'(DATA_WIDTH - 1));

    // Latch operands on go, then iterate DATA_WIDTH times and stop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_hi    <= '0;
            acc_lo    <= '0;
            operand_b <= '0;
            div_mode  <= 1'b0;
            running   <= 1'b0;
            cnt       <= '0;
        end else if (go) begin
            acc_hi    <= '0;
            acc_lo    <= a;
            operand_b <= b;
            div_mode  <= is_div;
            running   <= 1'b1;
            cnt       <= '0;
        end else if (running) begin
            acc_hi <= hi;
            acc_lo <= lo;
            cnt    <= cnt + CNT_WIDTH'(1);
            if (last) begin
                running <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/ula_seq.sv
// Registered stack-machine ALU. Logic and add/sub ops finish one cycle after
// accept; MULT/DIV hand off to the iterative engine and hold busy until done.
module ula_seq
    import ula_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int FUNCT_WIDTH = 5
) (
    input  logic      clk,
    input  logic      rst_n,
    ula_seq_if.slave  bus
);
    state_t                 state;
    logic                   busy_q;
    logic                   done_q;
    logic [DATA_WIDTH-1:0]  res_q;
    logic [DATA_WIDTH-1:0]  hi_q;
    logic                   z_q, n_q, c_q, dz_q;

    logic [FUNCT_WIDTH-1:0] funct;
    logic [1:0]             low;
    logic [2:0]             op;
    logic                   accept;
    logic                   y_zero;
    logic                   eng_go;
    logic                   eng_is_div;
    logic [DATA_WIDTH-1:0]  eng_hi;
    logic [DATA_WIDTH-1:0]  eng_lo;
    logic                   eng_last;

    logic [DATA_WIDTH:0]    add_full;
    logic [DATA_WIDTH:0]    sub_full;
    logic [DATA_WIDTH:0]    nsub_full;
    logic [DATA_WIDTH-1:0]  alu_res;
    logic                   alu_c;

    assign funct      = bus.funct;
    assign low        = funct[1:0];
    assign accept     = bus.start && (state == IDLE);
    assign y_zero     = (bus.Y == '0);
    assign eng_is_div = (low == LOW_DIV);
    assign eng_go     = accept && ((low == LOW_MULT) || (eng_is_div && !y_zero));

    assign add_full  = {1'b0, bus.T} + {1'b0, bus.Y};
    assign sub_full  = {1'b0, bus.T} - {1'b0, bus.Y};
    assign nsub_full = {1'b0, bus.Y} - {1'b0, bus.T};

    // Single-cycle datapath; the reserved group behaves as BYPASST.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        op      = (low == LOW_ALU) ? funct[4:2] : OP_BYPASST;
        case (op)
            OP_BYPASST: alu_res = bus.T;
            OP_AND:     alu_res = bus.T & bus.Y;
            OP_SUB:     begin alu_res = sub_full[DATA_WIDTH-1:0];  alu_c = sub_full[DATA_WIDTH];  end
            OP_OR:      alu_res = bus.T | bus.Y;
            OP_ADD:     begin alu_res = add_full[DATA_WIDTH-1:0];  alu_c = add_full[DATA_WIDTH];  end
            OP_XOR:     alu_res = bus.T ^ bus.Y;
            OP_NSUB:    begin alu_res = nsub_full[DATA_WIDTH-1:0]; alu_c = nsub_full[DATA_WIDTH]; end
            OP_BYPASSY: alu_res = bus.Y;
            default:    alu_res = bus.T;
        endcase
    end

    ula_seq_muldiv #(.DATA_WIDTH(DATA_WIDTH)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .go     (eng_go),
        .is_div (eng_is_div),
        .a      (bus.T),
        .b      (bus.Y),
        .hi     (eng_hi),
        .lo     (eng_lo),
        .last   (eng_last)
    );

    // Controller FSM with all visible outputs registered; done is a one-cycle pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            res_q  <= '0;
            hi_q   <= '0;
            z_q    <= 1'b0;
            n_q    <= 1'b0;
            c_q    <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (low)
                            LOW_MULT: begin
                                state  <= MUL;
                                busy_q <= 1'b1;
                            end
                            LOW_DIV: begin
                                if (y_zero) begin
                                    res_q  <= '1;
                                    hi_q   <= bus.T;
                                    z_q    <= 1'b0;
                                    n_q    <= 1'b1;
                                    c_q    <= 1'b0;
                                    dz_q   <= 1'b1;
                                    done_q <= 1'b1;
                                end else begin
                                    state  <= DIV;
                                    busy_q <= 1'b1;
                                end
                            end
                            default: begin
                                res_q  <= alu_res;
                                hi_q   <= '0;
                                z_q    <= (alu_res == '0);
                                n_q    <= alu_res[DATA_WIDTH-1];
                                c_q    <= alu_c;
                                dz_q   <= 1'b0;
                                done_q <= 1'b1;
                            end
                        endcase
                    end
                end
                MUL, DIV: begin
                    if (eng_last) begin
                        res_q  <= eng_lo;
                        hi_q   <= eng_hi;
                        z_q    <= (eng_lo == '0);
                        n_q    <= eng_lo[DATA_WIDTH-1];
                        c_q    <= 1'b0;
                        dz_q   <= 1'b0;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.Result   = res_q;
    assign bus.ResultHi = hi_q;
    assign bus.flagZ    = z_q;
    assign bus.flagN    = n_q;
    assign bus.flagC    = c_q;
    assign bus.flagDZ   = dz_q;
endmodule

// File: tb/tb_ula_seq.sv
// Directed bench for ula_seq (DATA_WIDTH=16) with hand-computed expectations.
module tb_ula_seq;
    localparam logic [4:0] F_BYPASST = 5'b00000;
    localparam logic [4:0] F_AND     = 5'b00100;
    localparam logic [4:0] F_SUB     = 5'b01000;
    localparam logic [4:0] F_OR      = 5'b01100;
    localparam logic [4:0] F_ADD     = 5'b10000;
    localparam logic [4:0] F_XOR     = 5'b10100;
    localparam logic [4:0] F_NSUB    = 5'b11000;
    localparam logic [4:0] F_BYPASSY = 5'b11100;
    localparam logic [4:0] F_MULT    = 5'b00010;
    localparam logic [4:0] F_DIV     = 5'b00001;
    localparam logic [4:0] F_RSVD    = 5'b00011;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    ula_seq_if #(.DATA_WIDTH(16), .FUNCT_WIDTH(5)) bus ();

    ula_seq #(.DATA_WIDTH(16), .FUNCT_WIDTH(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] flags();
        return {bus.flagZ, bus.flagN, bus.flagC, bus.flagDZ};
    endfunction

    // Present a request for one edge; returns #1 after the accept edge
    task automatic start_op(input logic [15:0] t, input logic [15:0] y, input logic [4:0] f);
        @(negedge clk);
        bus.start = 1'b1;
        bus.T     = t;
        bus.Y     = y;
        bus.funct = f;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Step until done (bounded); optionally pulse a junk start at cycle 'poke'
    task automatic wait_done(input int limit, input int poke, output int cycles, output int busy_cnt);
        cycles   = 0;
        busy_cnt = 0;
        while (!bus.done && cycles < limit) begin
            if (bus.busy) busy_cnt++;
            if (cycles == poke) begin
                bus.start = 1'b1;
                bus.funct = F_ADD;
                bus.T     = 16'h0001;
                bus.Y     = 16'h0001;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            errors++; $display("[TB] FAIL reset_ctl got busy,done=%b want 00", {bus.busy, bus.done});
        end
        checks++;
        if ({bus.ResultHi, bus.Result} !== 32'h0) begin
            errors++; $display("[TB] FAIL reset_result got %h want 00000000", {bus.ResultHi, bus.Result});
        end
        checks++;
        if (flags() !== 4'b0000) begin
            errors++; $display("[TB] FAIL reset_flags got %b want 0000", flags());
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        int cyc, bcnt;
        start_op(16'hFFFF, 16'h0001, F_ADD);
        wait_done(5, -1, cyc, bcnt);
        checks++;
        if (cyc !== 0 || bcnt !== 0) begin
            errors++; $display("[TB] FAIL add_latency got cyc=%0d busy=%0d want 0/0", cyc, bcnt);
        end
        checks++;
        if ({bus.ResultHi, bus.Result} !== 32'h0) begin
            errors++; $display("[TB] FAIL add_result got %h want 00000000", {bus.ResultHi, bus.Result});
        end
        checks++;
        if (flags() !== 4'b1010) begin
            errors++; $display("[TB] FAIL add_flags got ZNCD=%b want 1010", flags());
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b0) begin
            errors++; $display("[TB] FAIL add_done_pulse got %b want 0", bus.done);
        end
    endtask

    task automatic test_sub_nsub();
        int cyc, bcnt;
        start_op(16'h0003, 16'h0005, F_SUB);
        wait_done(5, -1, cyc, bcnt);
        checks++;
        if (bus.done !== 1'b1 || bus.Result !== 16'hFFFE || flags() !== 4'b0110) begin
            errors++; $display("[TB] FAIL sub got done=%b res=%h ZNCD=%b want 1 FFFE 0110", bus.done, bus.Result, flags());
        end
        start_op(16'h0003, 16'h0005, F_NSUB);
        wait_done(5, -1, cyc, bcnt);
        checks++;
        if (bus.done !== 1'b1 || bus.Result !== 16'h0002 || flags() !== 4'b0000) begin
            errors++; $display("[TB] FAIL nsub got done=%b res=%h ZNCD=%b want 1 0002 0000", bus.done, bus.Result, flags());
        end
        start_op(16'h0005, 16'h0003, F_NSUB);
        wait_done(5, -1, cyc, bcnt);
        checks++;
        if (bus.Result !== 16'hFFFE || bus.flagC !== 1'b1) begin
            errors++; $display("[TB] FAIL nsub_borrow got res=%h C=%b want FFFE 1", bus.Result, bus.flagC);
        end
    endtask

    task automatic test_logic();
        logic [4:0]  fv [5] = '{F_AND, F_OR, F_XOR, F_BYPASSY, F_BYPASST};
        logic [15:0] ev [5] = '{16'h00F0, 16'hFFF0, 16'hFF00, 16'h0FF0, 16'hF0F0};
        logic        nv [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int cyc, bcnt;
        for (int i = 0; i < 5; i++) begin
            start_op(16'hF0F0, 16'h0FF0, fv[i]);
            wait_done(5, -1, cyc, bcnt);
            checks++;
            if (bus.Result !== ev[i] || bus.flagN !== nv[i] || bus.ResultHi !== 16'h0) begin
                errors++; $display("[TB] FAIL logic_%0d got res=%h N=%b hi=%h want %h %b 0000", i, bus.Result, bus.flagN, bus.ResultHi, ev[i], nv[i]);
            end
        end
    endtask

    task automatic test_mult();
        int cyc, bcnt;
        start_op(16'hFFFF, 16'hFFFF, F_MULT);
        wait_done(40, 5, cyc, bcnt);
        checks++;
        if (bus.done !== 1'b1) begin
            errors++; $display("[TB] FAIL mult_timeout got done=%b want 1", bus.done);
        end
        checks++;
        if (cyc !== 16 || bcnt !== 16 || bus.busy !== 1'b0) begin
            errors++; $display("[TB] FAIL mult_timing got cyc=%0d busycnt=%0d busy=%b want 16 16 0", cyc, bcnt, bus.busy);
        end
        checks++;
        if ({bus.ResultHi, bus.Result} !== 32'hFFFE_0001 || flags() !== 4'b0000) begin
            errors++; $display("[TB] FAIL mult_result got %h ZNCD=%b want FFFE0001 0000", {bus.ResultHi, bus.Result}, flags());
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b0 || bus.Result !== 16'h0001) begin
            errors++; $display("[TB] FAIL mult_ignored_start got done=%b res=%h want 0 0001", bus.done, bus.Result);
        end
        start_op(16'h1234, 16'h0010, F_MULT);
        wait_done(40, -1, cyc, bcnt);
        checks++;
        if ({bus.ResultHi, bus.Result} !== 32'h0001_2340) begin
            errors++; $display("[TB] FAIL mult_shift got %h want 00012340", {bus.ResultHi, bus.Result});
        end
    endtask

    task automatic test_div();
        int cyc, bcnt;
        start_op(16'h0064, 16'h0007, F_DIV);
        wait_done(40, -1, cyc, bcnt);
        checks++;
        if (bus.done !== 1'b1 || cyc !== 16 || bcnt !== 16) begin
            errors++; $display("[TB] FAIL div_timing got done=%b cyc=%0d busycnt=%0d want 1 16 16", bus.done, cyc, bcnt);
        end
        checks++;
        if (bus.Result !== 16'h000E || bus.ResultHi !== 16'h0002 || flags() !== 4'b0000) begin
            errors++; $display("[TB] FAIL div_result got q=%h r=%h ZNCD=%b want 000E 0002 0000", bus.Result, bus.ResultHi, flags());
        end
        start_op(16'h0064, 16'h0000, F_DIV);
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("[TB] FAIL divz_timing got done=%b busy=%b want 1 0", bus.done, bus.busy);
        end
        checks++;
        if (bus.Result !== 16'hFFFF || bus.ResultHi !== 16'h0064 || flags() !== 4'b0101) begin
            errors++; $display("[TB] FAIL divz_result got q=%h r=%h ZNCD=%b want FFFF 0064 0101", bus.Result, bus.ResultHi, flags());
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bcnt;
        start_op(16'h0064, 16'h0007, F_DIV);
        wait_done(40, -1, cyc, bcnt);
        checks++;
        if (bus.done !== 1'b1 || bus.Result !== 16'h000E) begin
            errors++; $display("[TB] FAIL b2b_div got done=%b q=%h want 1 000E", bus.done, bus.Result);
        end
        bus.start = 1'b1;
        bus.T     = 16'h00AB;
        bus.Y     = 16'h1111;
        bus.funct = F_RSVD;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || bus.Result !== 16'h00AB || bus.ResultHi !== 16'h0 || flags() !== 4'b0000) begin
            errors++; $display("[TB] FAIL b2b_rsvd got done=%b res=%h hi=%h ZNCD=%b want 1 00AB 0000 0000", bus.done, bus.Result, bus.ResultHi, flags());
        end
    endtask

    task automatic test_reset_mid_mult();
        int done_seen;
        start_op(16'h1234, 16'h0010, F_MULT);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done} !== 2'b00 || {bus.ResultHi, bus.Result} !== 32'h0 || flags() !== 4'b0000) begin
            errors++; $display("[TB] FAIL midreset got busy,done=%b res=%h ZNCD=%b want 00 00000000 0000", {bus.busy, bus.done}, {bus.ResultHi, bus.Result}, flags());
        end
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin
            errors++; $display("[TB] FAIL midreset_quiet got %0d active cycles want 0", done_seen);
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.T     = '0;
        bus.Y     = '0;
        bus.funct = '0;
        test_reset();
        test_add();
        test_sub_nsub();
        test_logic();
        test_mult();
        test_div();
        test_back_to_back();
        test_reset_mid_mult();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ula_seq.md
Name: ula_seq

Overview:
- Parametrised, registered successor to the stack-machine ALU.
- Combinational-class ops (bypass, logic, add/sub) complete in one cycle.
- MULT and DIV are iterative: DATA_WIDTH cycles each, full-width products, quotient plus remainder, and richer flags.
- Sits between the T/Y stack datapath and the control unit; the control unit stalls on busy.

Parameters:
- DATA_WIDTH, 16, operand/result width; any value >= 4.
- FUNCT_WIDTH, 5, funct code width; fixed at 5 (encoding below).
- CNT_WIDTH, $clog2(DATA_WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request; accepted on a rising edge when start=1 and busy=0.
- T  in  DATA_WIDTH  operand 1 (top of stack); sampled at accept.
- Y  in  DATA_WIDTH  operand 2 (Y bus); sampled at accept.
- funct  in  FUNCT_WIDTH  operation; sampled at accept.
- busy  out  1  multi-cycle op in progress.
- done  out  1  one-cycle pulse; Result/ResultHi/flags valid from this cycle.
- Result  out  DATA_WIDTH  result, low product, or quotient.
- ResultHi  out  DATA_WIDTH  high product (MULT), remainder (DIV), else 0.
- flagZ  out  1  Result == 0.
- flagN  out  1  Result[DATA_WIDTH-1].
- flagC  out  1  ADD: carry-out. SUB: borrow (T<Y). NSUB: borrow (Y<T). Else 0.
- flagDZ  out  1  DIV with Y==0.

Behaviour:
- Encoding, with funct[1:0]==00 selecting on funct[4:2]:
  - 000 BYPASST, 001 AND, 010 SUB (T-Y), 011 OR, 100 ADD, 101 XOR, 110 NSUB (Y-T), 111 BYPASSY.
  - funct[1:0]==10: MULT. funct[1:0]==01: DIV.
  - funct[1:0]==11: reserved; executes as BYPASST.
- All arithmetic is unsigned, modulo 2^DATA_WIDTH except MULT, which gives a 2*DATA_WIDTH product {ResultHi,Result}.
- Reset (rst_n=0 at an edge):
  - State -> IDLE; counter cleared.
  - busy, done, Result, ResultHi and all flags -> 0.
  - Aborts any in-flight MULT/DIV with no done pulse.
- FSM states:
  - IDLE -> IDLE on single-cycle accept; outputs registered at the accept edge.
  - IDLE -> MUL or DIV on MULT/DIV accept.
  - MUL/DIV -> IDLE after DATA_WIDTH iterations.
- Single-cycle latency: accept at edge k; outputs and done=1 in the cycle after edge k. busy never rises.
- MULT: shift-add, one bit per cycle.
  - busy=1 after accept edge k through edge k+DATA_WIDTH.
  - Final product is written at edge k+DATA_WIDTH; done=1 for the cycle after it; busy=0 in that cycle.
- DIV: restoring division, one quotient bit per cycle, same timing as MULT.
  - Result = T/Y, ResultHi = T%Y.
- DIV by zero: detected at accept; no iteration.
  - Next cycle: done=1, Result=all ones, ResultHi=T, flagDZ=1, busy never rises.
- Flags are registered together with Result. flagDZ=0 for every op except DIV-by-zero.
- start while busy=1 is ignored; no queuing.
- Back-to-back: start may be accepted in the same cycle done=1, since busy=0 then.
- Outputs hold their last values until the next completion. done is a pulse only.
- Changing T/Y/funct while busy has no effect, because operands are latched at accept.

Decomposition:
- Package ula_pkg:
  - Funct constants: BYPASST..BYPASSY 3-bit op field, plus MULT/DIV/reserved low-bit codes.
  - FSM state enum {IDLE, MUL, DIV}.
- One sub-module, ula_seq_muldiv:
  - Iterative shift-add/restoring engine with latched operands, counter and accumulator.
  - Interface: go, is_div, a, b, hi, lo, last.
- The top level holds the single-cycle datapath, the FSM, the flag logic and the output registers.

Test Plan:
- Reset mid-MULT: start MULT T=0x1234, Y=0x0010; assert rst_n=0 at cycle 5 -> next cycle all outputs 0, busy=0, no done pulse afterwards.
- ADD carry: T=0xFFFF, Y=0x0001, funct=10000 -> done after 1 cycle; Result=0x0000, flagZ=1, flagC=1, flagN=0, busy never high.
- SUB/NSUB: T=0x0003, Y=0x0005 -> SUB Result=0xFFFE, flagC=1, flagN=1; NSUB Result=0x0002, flagC=0.
- MULT (DATA_WIDTH=16): T=0xFFFF, Y=0xFFFF -> busy high 16 cycles, done on cycle 17; {ResultHi,Result}=0xFFFE_0001.
  - A start pulsed mid-operation is ignored.
- DIV: T=0x0064, Y=0x0007 -> done after 16 cycles; Result=0x000E, ResultHi=0x0002, flagDZ=0.
  - Then DIV T=0x0064, Y=0 -> done next cycle; Result=0xFFFF, ResultHi=0x0064, flagDZ=1.
- Reserved/back-to-back: funct=00011, T=0x00AB -> Result=0x00AB.
  - A start accepted in the done cycle of a DIV completes normally.
